// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the memory bus arbiter.
// Holds FSM state encodings, default bus widths and counter width.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signal bundle of the shared memory bus.
// master: arbiter view; slave: requesters plus memory view.
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N_CPU  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [N_CPU-1:0]        req_rd;
    logic [N_CPU-1:0]        req_wr;
    logic [N_CPU*ADDR_W-1:0] req_addr;
    logic [N_CPU*DATA_W-1:0] req_wdata;
    logic [N_CPU-1:0]        grant;
    logic [N_CPU-1:0]        rd_dn;
    logic [N_CPU-1:0]        wr_dn;
    logic [DATA_W-1:0]       rdata;
    logic                    bus_busy;
    logic [ADDR_W-1:0]       bus_addr;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    mem_ack;
    logic                    timeout_err;

    modport master (
        input  req_rd, req_wr, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output grant, rd_dn, wr_dn, rdata, bus_busy, bus_addr,
        output mem_addr, mem_wdata, mem_rd, mem_wr, timeout_err
    );

    modport slave (
        output req_rd, req_wr, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  grant, rd_dn, wr_dn, rdata, bus_busy, bus_addr,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, timeout_err
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first active requester after last_ptr.
// Ports: req (active vector), last_ptr -> idx, valid.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int            c;
        logic [IW-1:0] ci;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        ci    = '0;
        // Offset 1 first, offset N (last_ptr itself) last.
        for (int k = 1; k <= N; k++) begin
            c = int'(last_ptr) + k;
            if (c >= N) c = c - N;
            ci = IW'(c);
            if (!valid && req[ci]) begin
                valid = 1'b1;
                idx   = ci;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared memory bus.
// Ports: clk, rst (sync, active-high), bus (master modport).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N_CPU   = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    mem_bus_arbiter_if.master bus
);

    localparam int IW = (N_CPU > 1) ? $clog2(N_CPU) : 1;
    localparam logic [IW-1:0]    LAST_RST = IW'(N_CPU - 1);
    localparam logic [N_CPU-1:0] ONE      = N_CPU'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    arb_state_t        state;
    logic [IW-1:0]     last_ptr;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic [N_CPU-1:0]  active;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              op_wr;
    logic              abort;
    logic [CNT_W-1:0]  cnt;

    assign active = bus.req_rd | bus.req_wr;

    rr_pick #(.N(N_CPU), .IW(IW)) u_pick (
        .req      (active),
        .last_ptr (last_ptr),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ARB_IDLE;
            last_ptr        <= LAST_RST;
            idx             <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            op_wr           <= 1'b0;
            abort           <= 1'b0;
            cnt             <= '0;
            bus.grant       <= '0;
            bus.rd_dn       <= '0;
            bus.wr_dn       <= '0;
            bus.rdata       <= '0;
            bus.bus_busy    <= 1'b0;
            bus.bus_addr    <= '0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_rd      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.rd_dn       <= '0;
            bus.wr_dn       <= '0;
            bus.timeout_err <= 1'b0;
            bus.mem_rd      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        idx     <= pick_idx;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        // rd+wr together is a write
                        op_wr   <= bus.req_wr[pick_idx];
                        state   <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    bus.grant     <= ONE << idx;
                    bus.bus_busy  <= 1'b1;
                    bus.bus_addr  <= addr_q;
                    bus.mem_addr  <= addr_q;
                    bus.mem_wdata <= wdata_q;
                    bus.mem_rd    <= ~op_wr;
                    bus.mem_wr    <= op_wr;
                    cnt           <= '0;
                    abort         <= 1'b0;
                    state         <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (bus.mem_ack) begin
                        if (!op_wr) rdata_q <= bus.mem_rdata;
                        state <= ARB_DONE;
                    end else if (cnt == CNT_MAX) begin
                        abort   <= 1'b1;
                        rdata_q <= '1;
                        state   <= ARB_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB_DONE: begin
                    bus.rd_dn       <= op_wr ? '0 : ONE << idx;
                    bus.wr_dn       <= op_wr ? ONE << idx : '0;
                    if (!op_wr) bus.rdata <= rdata_q;
                    bus.timeout_err <= abort;
                    bus.grant       <= '0;
                    bus.bus_busy    <= 1'b0;
                    bus.bus_addr    <= '0;
                    last_ptr        <= idx;
                    state           <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
